// File: rtl/sid_reg_slave.sv
// sid_reg_slave
//   Register slave for a three-voice SID-style sound generator. A host
//   writes one byte at a time over an asynchronous strobe bus; each
//   accepted write updates one byte-lane of the voice/filter registers.
//
// Ports
//   clk       in   1   system clock, rising edge
//   rst       in   1   asynchronous active-high reset
//   ui_in     in   8   [7] write strobe, [6:5] reserved (00), [4:3] voice, [2:0] addr
//   uio_in    in   8   write data
//   freq      out 48   voice v frequency at [16v+15:16v]
//   pw        out 36   voice v pulse width at [12v+11:12v]
//   ad/sr/ctrl out 24  voice v attack-decay / sustain-release / control at [8v+7:8v]
//   fc        out 11   filter cutoff
//   res_filt  out  8   resonance / filter routing
//   mode_vol  out  8   filter mode / master volume
//   gate_on   out  3   one-cycle pulse when a voice's gate bit goes 0->1
//   wr_pulse  out  1   one-cycle pulse per accepted write, with the update
//   err       out  1   sticky, a malformed write was seen
//
// Bus protocol: the host presents ui_in[6:0] and uio_in at least one clock
// before raising ui_in[7] and keeps them stable until ui_in[7] falls. The
// strobe is synchronised through two flops; a write is taken on the first
// cycle the synchronised strobe is high after having been seen low, and is
// committed on the next rising edge (two edges after the first high sample).
module sid_reg_slave (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  input  logic [7:0]  uio_in,
  output logic [47:0] freq,
  output logic [35:0] pw,
  output logic [23:0] ad,
  output logic [23:0] sr,
  output logic [23:0] ctrl,
  output logic [10:0] fc,
  output logic [7:0]  res_filt,
  output logic [7:0]  mode_vol,
  output logic [2:0]  gate_on,
  output logic        wr_pulse,
  output logic        err
);

  logic        r_s1, r_s2, r_s2_d;
  logic        r_v1, r_v2;
  logic        r_armed;
  logic [47:0] r_freq;
  logic [35:0] r_pw;
  logic [23:0] r_ad, r_sr, r_ctrl;
  logic [10:0] r_fc;
  logic [7:0]  r_res_filt, r_mode_vol;
  logic [2:0]  r_gate_on;
  logic        r_wr_pulse, r_err;

  logic        w_detect, w_bad;
  logic [1:0]  w_voice;
  logic [2:0]  w_addr;
  logic [7:0]  w_data;
  logic [5:0]  w_fidx, w_pidx;
  logic [4:0]  w_bidx;

  assign w_voice = ui_in[4:3];
  assign w_addr  = ui_in[2:0];
  assign w_data  = uio_in;
  assign w_fidx  = {w_voice, 4'b0000};
  assign w_pidx  = {4'b0000, w_voice} * 6'd12;
  assign w_bidx  = {w_voice, 3'b000};

  // Rising edge of the synchronised strobe, only once a genuine low has
  // been observed since reset.
  assign w_detect = r_s2 & ~r_s2_d & r_armed;

  assign w_bad = (ui_in[6:5] != 2'b00) ||
                 ((w_voice != 2'd3) && (w_addr == 3'd7)) ||
                 ((w_voice == 2'd3) && w_addr[2]);

  // r_v1/r_v2 mark when r_s2 holds a real sample of the pin rather than its
  // reset value. Without them a strobe held high across reset release would
  // look like a fresh low->high edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s2_d  <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_s1   <= ui_in[7];
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
      r_v1   <= 1'b1;
      r_v2   <= r_v1;
      if (r_v2 && !r_s2) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_freq     <= '0;
      r_pw       <= '0;
      r_ad       <= '0;
      r_sr       <= '0;
      r_ctrl     <= '0;
      r_fc       <= '0;
      r_res_filt <= '0;
      r_mode_vol <= '0;
      r_gate_on  <= '0;
      r_wr_pulse <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_gate_on  <= '0;
      r_wr_pulse <= 1'b0;
      if (w_detect) begin
        if (w_bad) begin
          r_err <= 1'b1;
        end else begin
          r_wr_pulse <= 1'b1;
          if (w_voice == 2'd3) begin
            case (w_addr)
              3'd0:    r_fc[2:0]  <= w_data[2:0];
              3'd1:    r_fc[10:3] <= w_data;
              3'd2:    r_res_filt <= w_data;
              3'd3:    r_mode_vol <= w_data;
              default: ;
            endcase
          end else begin
            case (w_addr)
              3'd0: r_freq[w_fidx +: 8]         <= w_data;
              3'd1: r_freq[w_fidx + 6'd8 +: 8]  <= w_data;
              3'd2: r_pw[w_pidx +: 8]           <= w_data;
              3'd3: r_pw[w_pidx + 6'd8 +: 4]    <= w_data[3:0];
              3'd4: r_ad[w_bidx +: 8]           <= w_data;
              3'd5: r_sr[w_bidx +: 8]           <= w_data;
              3'd6: begin
                r_ctrl[w_bidx +: 8] <= w_data;
                // Gate pulse only on a 0->1 transition of the stored bit.
                if (w_data[0] && !r_ctrl[w_bidx]) r_gate_on[w_voice] <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign freq     = r_freq;
  assign pw       = r_pw;
  assign ad       = r_ad;
  assign sr       = r_sr;
  assign ctrl     = r_ctrl;
  assign fc       = r_fc;
  assign res_filt = r_res_filt;
  assign mode_vol = r_mode_vol;
  assign gate_on  = r_gate_on;
  assign wr_pulse = r_wr_pulse;
  assign err      = r_err;

endmodule

// File: tb/tb_sid_reg_slave.sv
module tb_sid_reg_slave;

  logic        clk;
  logic        rst;
  logic [7:0]  ui_in;
  logic [7:0]  uio_in;
  logic [47:0] freq;
  logic [35:0] pw;
  logic [23:0] ad, sr, ctrl;
  logic [10:0] fc;
  logic [7:0]  res_filt, mode_vol;
  logic [2:0]  gate_on;
  logic        wr_pulse;
  logic        err;

  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_gate [3];

  sid_reg_slave dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uio_in(uio_in),
    .freq(freq), .pw(pw), .ad(ad), .sr(sr), .ctrl(ctrl),
    .fc(fc), .res_filt(res_filt), .mode_vol(mode_vol),
    .gate_on(gate_on), .wr_pulse(wr_pulse), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse counters, sampled on the falling edge
  always @(negedge clk) begin
    if (wr_pulse === 1'b1) n_wr++;
    for (int v = 0; v < 3; v++) if (gate_on[v] === 1'b1) n_gate[v]++;
  end

  // driver: one complete strobe cycle, setup one clock before the rise
  task automatic do_write(input logic [1:0] v, input logic [2:0] a,
                          input logic [7:0] d, input logic [1:0] rsv);
    @(negedge clk);
    ui_in  = {1'b0, rsv, v, a};
    uio_in = d;
    @(negedge clk);
    ui_in[7] = 1'b1;
    repeat (3) @(negedge clk);
    ui_in[7] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; ui_in = '0; uio_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({freq, pw, ad, sr, ctrl, fc, res_filt, mode_vol, gate_on, wr_pulse, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got freq=%h pw=%h ctrl=%h err=%b, want all zero", freq, pw, ctrl, err);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_freq;
    int w0;
    w0 = n_wr;
    do_write(2'd0, 3'd0, 8'hD6, 2'b00);
    do_write(2'd0, 3'd1, 8'h1C, 2'b00);
    checks++;
    if (freq !== 48'h0000_0000_1CD6) begin errors++; $display("FAIL freq_v0: got %h want %h", freq, 48'h1CD6); end
    checks++;
    if (n_wr - w0 !== 2) begin errors++; $display("FAIL freq_wr_pulses: got %0d want 2", n_wr - w0); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL freq_err: got %b want 0", err); end
  endtask

  task automatic test_gate;
    do_write(2'd0, 3'd4, 8'h00, 2'b00);
    do_write(2'd0, 3'd5, 8'hF0, 2'b00);
    do_write(2'd0, 3'd6, 8'h21, 2'b00);
    checks++;
    if (sr !== 24'h0000F0) begin errors++; $display("FAIL gate_sr: got %h want %h", sr, 24'hF0); end
    checks++;
    if (ctrl !== 24'h000021) begin errors++; $display("FAIL gate_ctrl: got %h want %h", ctrl, 24'h21); end
    checks++;
    if (n_gate[0] !== 1 || n_gate[1] !== 0 || n_gate[2] !== 0) begin
      errors++; $display("FAIL gate_first: got %0d/%0d/%0d want 1/0/0", n_gate[0], n_gate[1], n_gate[2]);
    end
    do_write(2'd0, 3'd6, 8'h21, 2'b00);
    checks++;
    if (n_gate[0] !== 1) begin errors++; $display("FAIL gate_rewrite: got %0d want 1", n_gate[0]); end
    do_write(2'd1, 3'd6, 8'h01, 2'b00);
    checks++;
    if (n_gate[1] !== 1 || n_gate[0] !== 1 || ctrl !== 24'h000121) begin
      errors++; $display("FAIL gate_v1: got g1=%0d g0=%0d ctrl=%h want 1 1 000121", n_gate[1], n_gate[0], ctrl);
    end
  endtask

  task automatic test_pw;
    do_write(2'd1, 3'd2, 8'h34, 2'b00);
    do_write(2'd1, 3'd3, 8'hA5, 2'b00);
    checks++;
    if (pw !== 36'h000534000) begin errors++; $display("FAIL pw_v1: got %h want %h", pw, 36'h000534000); end
  endtask

  task automatic test_filter;
    do_write(2'd3, 3'd0, 8'hFF, 2'b00);
    do_write(2'd3, 3'd1, 8'hAB, 2'b00);
    do_write(2'd3, 3'd2, 8'h5A, 2'b00);
    do_write(2'd3, 3'd3, 8'h0F, 2'b00);
    checks++;
    if (fc !== 11'h55F) begin errors++; $display("FAIL filter_fc: got %h want %h", fc, 11'h55F); end
    checks++;
    if (res_filt !== 8'h5A || mode_vol !== 8'h0F) begin
      errors++; $display("FAIL filter_rv: got %h %h want 5a 0f", res_filt, mode_vol);
    end
    checks++;
    if (freq !== 48'h1CD6 || pw !== 36'h000534000 || ad !== 24'h0 || sr !== 24'hF0 || ctrl !== 24'h000121) begin
      errors++; $display("FAIL filter_voices_kept: got freq=%h pw=%h ad=%h sr=%h ctrl=%h", freq, pw, ad, sr, ctrl);
    end
  endtask

  task automatic test_bad;
    int w0;
    w0 = n_wr;
    do_write(2'd2, 3'd7, 8'h55, 2'b00);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL bad_addr_err: got %b want 1", err); end
    do_write(2'd0, 3'd0, 8'h99, 2'b01);
    do_write(2'd3, 3'd5, 8'h77, 2'b00);
    checks++;
    if (n_wr !== w0) begin errors++; $display("FAIL bad_wr_pulse: got %0d pulses want 0", n_wr - w0); end
    checks++;
    if (freq !== 48'h1CD6 || pw !== 36'h000534000 || ad !== 24'h0 || sr !== 24'hF0 ||
        ctrl !== 24'h000121 || fc !== 11'h55F || res_filt !== 8'h5A || mode_vol !== 8'h0F) begin
      errors++; $display("FAIL bad_regs_kept: got freq=%h fc=%h rf=%h mv=%h", freq, fc, res_filt, mode_vol);
    end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL bad_err_sticky: got %b want 1", err); end
  endtask

  task automatic test_latency;
    @(negedge clk);
    ui_in = {1'b0, 2'b00, 2'd2, 3'd0}; uio_in = 8'h77;
    @(negedge clk);
    ui_in[7] = 1'b1;
    @(posedge clk); #1;            // edge N
    @(posedge clk); #1;            // edge N+1
    checks++;
    if (wr_pulse !== 1'b0 || freq !== 48'h1CD6) begin
      errors++; $display("FAIL latency_n1: got wr=%b freq=%h want 0 %h", wr_pulse, freq, 48'h1CD6);
    end
    @(posedge clk); #1;            // edge N+2
    checks++;
    if (wr_pulse !== 1'b1 || freq !== 48'h0077_0000_1CD6) begin
      errors++; $display("FAIL latency_n2: got wr=%b freq=%h want 1 %h", wr_pulse, freq, 48'h0077_0000_1CD6);
    end
    @(posedge clk); #1;
    checks++;
    if (wr_pulse !== 1'b0) begin errors++; $display("FAIL latency_width: got %b want 0", wr_pulse); end
    @(negedge clk);
    ui_in[7] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_long_strobe;
    int w0;
    w0 = n_wr;
    @(negedge clk);
    ui_in = {1'b0, 2'b00, 2'd2, 3'd1}; uio_in = 8'h42;
    @(negedge clk);
    ui_in[7] = 1'b1;
    repeat (20) @(negedge clk);
    ui_in[7] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (n_wr - w0 !== 1 || freq !== 48'h4277_0000_1CD6) begin
      errors++; $display("FAIL long_strobe: got %0d writes freq=%h want 1 %h", n_wr - w0, freq, 48'h4277_0000_1CD6);
    end
  endtask

  task automatic test_reset_strobe;
    int w0;
    @(negedge clk);
    ui_in = {1'b0, 2'b00, 2'd0, 3'd0}; uio_in = 8'h11;
    @(negedge clk);
    ui_in[7] = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({freq, pw, ad, sr, ctrl, fc, res_filt, mode_vol, gate_on, wr_pulse, err} !== '0) begin
      errors++; $display("FAIL async_reset: got freq=%h fc=%h err=%b want all zero", freq, fc, err);
    end
    @(negedge clk);
    rst = 1'b0;
    w0 = n_wr;
    repeat (8) @(negedge clk);
    checks++;
    if (n_wr !== w0 || {freq, pw, ad, sr, ctrl, fc, res_filt, mode_vol, gate_on, wr_pulse, err} !== '0) begin
      errors++; $display("FAIL strobe_across_reset: got %0d writes freq=%h want 0 writes all zero", n_wr - w0, freq);
    end
    ui_in[7] = 1'b0;
    repeat (3) @(negedge clk);
    do_write(2'd0, 3'd0, 8'h11, 2'b00);
    checks++;
    if (n_wr - w0 !== 1 || freq !== 48'h11 || err !== 1'b0) begin
      errors++; $display("FAIL rewrite_after_reset: got %0d writes freq=%h err=%b want 1 11 0", n_wr - w0, freq, err);
    end
  endtask

  initial begin
    for (int v = 0; v < 3; v++) n_gate[v] = 0;
    test_reset;
    test_freq;
    test_gate;
    test_pw;
    test_filter;
    test_bad;
    test_latency;
    test_long_strobe;
    test_reset_strobe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
